// File: rtl/kogge_stone_adder_if.sv
// Operand/result bundle for the Kogge-Stone adder: master drives operands, slave returns the registered result.
interface kogge_stone_adder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output in_valid, A, B, Cin,
    input  out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output out_valid, Sum, Cout
  );
endinterface

// File: rtl/kogge_stone_adder.sv
// Kogge-Stone parallel-prefix adder, Sum/Cout = A + B + Cin, result registered with a valid flag.
// Latency 1 cycle; accepts a new operation every cycle, no backpressure.
module kogge_stone_adder #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  kogge_stone_adder_if.slave bus
);
  // Prefix positions: 0 holds Cin as a generate term, 1..WIDTH hold bits 0..WIDTH-1.
  localparam int NPOS   = WIDTH + 1;
  localparam int LEVELS = $clog2(NPOS);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NPOS-1:0]  g_cur;
  logic [NPOS-1:0]  p_cur;
  logic [NPOS-1:0]  g_nxt;
  logic [NPOS-1:0]  p_nxt;
  logic [NPOS-1:0]  carry;
  logic [WIDTH-1:0] sum_comb;

  assign g = bus.A & bus.B;
  assign p = bus.A ^ bus.B;

  always_comb begin
    g_cur = {g, bus.Cin};
    p_cur = {p, 1'b0};
    g_nxt = '0;
    p_nxt = '0;
    for (int lv = 0; lv < LEVELS; lv++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      // Positions below distance 2^lv have no partner and pass through unchanged.
      for (int j = (1 << lv); j < NPOS; j++) begin
        g_nxt[j] = g_cur[j] | (p_cur[j] & g_cur[j - (1 << lv)]);
        p_nxt[j] = p_cur[j] & p_cur[j - (1 << lv)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    carry = g_cur;
  end

  assign sum_comb = p ^ carry[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Sum       <= '0;
      bus.Cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Sum  <= sum_comb;
        bus.Cout <= carry[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_kogge_stone_adder.sv
// Drives five adder instances (WIDTH 4,1,5,8,16) in lockstep and checks them against an arithmetic model.
module tb_kogge_stone_adder;
  localparam int NDUT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vin;
  logic [15:0] a_in   [NDUT];
  logic [15:0] b_in   [NDUT];
  logic        cin_in [NDUT];
  logic [31:0] exp_res[NDUT];
  logic        exp_vld[NDUT];
  logic [31:0] o_res  [NDUT];
  logic        o_vld  [NDUT];

  int checks   = 0;
  int failures = 0;

  kogge_stone_adder_if #(.WIDTH(4))  if4 ();
  kogge_stone_adder_if #(.WIDTH(1))  if1 ();
  kogge_stone_adder_if #(.WIDTH(5))  if5 ();
  kogge_stone_adder_if #(.WIDTH(8))  if8 ();
  kogge_stone_adder_if #(.WIDTH(16)) if16 ();

  kogge_stone_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  kogge_stone_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  kogge_stone_adder #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(if5));
  kogge_stone_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  kogge_stone_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  assign if4.in_valid  = vin;
  assign if1.in_valid  = vin;
  assign if5.in_valid  = vin;
  assign if8.in_valid  = vin;
  assign if16.in_valid = vin;
  assign if4.A  = a_in[0][3:0];  assign if4.B  = b_in[0][3:0];  assign if4.Cin  = cin_in[0];
  assign if1.A  = a_in[1][0:0];  assign if1.B  = b_in[1][0:0];  assign if1.Cin  = cin_in[1];
  assign if5.A  = a_in[2][4:0];  assign if5.B  = b_in[2][4:0];  assign if5.Cin  = cin_in[2];
  assign if8.A  = a_in[3][7:0];  assign if8.B  = b_in[3][7:0];  assign if8.Cin  = cin_in[3];
  assign if16.A = a_in[4];       assign if16.B = b_in[4];       assign if16.Cin = cin_in[4];

  assign o_res[0] = {27'b0, if4.Cout,  if4.Sum};
  assign o_res[1] = {30'b0, if1.Cout,  if1.Sum};
  assign o_res[2] = {26'b0, if5.Cout,  if5.Sum};
  assign o_res[3] = {23'b0, if8.Cout,  if8.Sum};
  assign o_res[4] = {15'b0, if16.Cout, if16.Sum};
  assign o_vld[0] = if4.out_valid;
  assign o_vld[1] = if1.out_valid;
  assign o_vld[2] = if5.out_valid;
  assign o_vld[3] = if8.out_valid;
  assign o_vld[4] = if16.out_valid;

  function automatic int wid(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 5;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (32'd1 << wid(k)) - 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // One clock edge: the model captures what the adders see at the edge, then all outputs are compared.
  task automatic tick(input string tag);
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        exp_res[k] = 32'd0;
        exp_vld[k] = 1'b0;
      end else begin
        if (vin)
          exp_res[k] = 32'(a_in[k]) + 32'(b_in[k]) + 32'(cin_in[k]);
        exp_vld[k] = vin;
      end
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_w%0d_res", tag, wid(k)), o_res[k], exp_res[k]);
      check($sformatf("%s_w%0d_vld", tag, wid(k)), 32'(o_vld[k]), 32'(exp_vld[k]));
    end
  endtask

  task automatic rand_all(input bit corners);
    int r;
    logic [31:0] m;
    for (int k = 0; k < NDUT; k++) begin
      m = mask_of(k);
      r = $urandom_range(0, 7);
      if (corners && r == 0) begin
        a_in[k] = m[15:0]; b_in[k] = m[15:0]; cin_in[k] = 1'b1;
      end else if (corners && r == 1) begin
        a_in[k] = m[15:0]; b_in[k] = 16'd0; cin_in[k] = 1'b1;
      end else if (corners && r == 2) begin
        a_in[k] = 16'd0; b_in[k] = 16'd0; cin_in[k] = 1'($urandom_range(0, 1));
      end else begin
        a_in[k]   = 16'($urandom) & m[15:0];
        b_in[k]   = 16'($urandom) & m[15:0];
        cin_in[k] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a_in[0] = {12'b0, a}; b_in[0] = {12'b0, b}; cin_in[0] = c;
  endtask

  logic [3:0]  dir_a [6] = '{4'b1101, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0111};
  logic [3:0]  dir_b [6] = '{4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
  logic        dir_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] dir_e [6] = '{32'h18, 32'h1F, 32'h00, 32'h01, 32'h10, 32'h08};

  initial begin
    logic [8:0] idx;
    for (int k = 0; k < NDUT; k++) begin
      a_in[k] = mask_of(k)[15:0]; b_in[k] = mask_of(k)[15:0]; cin_in[k] = 1'b1;
      exp_res[k] = 32'd0; exp_vld[k] = 1'b0;
    end
    rst_n = 1'b0;
    vin   = 1'b1;
    #2;
    tick("rst0");
    tick("rst1");
    check("reset_sum4", o_res[0], 32'h00);
    check("reset_vld4", 32'(o_vld[0]), 32'd0);

    rst_n = 1'b1;
    tick("release");
    check("release_sum4", o_res[0], 32'h1F);
    check("release_vld4", 32'(o_vld[0]), 32'd1);

    for (int i = 0; i < 6; i++) begin
      rand_all(1'b1);
      set4(dir_a[i], dir_b[i], dir_c[i]);
      tick($sformatf("dir%0d", i));
      check($sformatf("dir%0d_const", i), o_res[0], dir_e[i]);
    end

    rand_all(1'b0);
    set4(4'b0101, 4'b0011, 1'b0);
    tick("hold_load");
    vin = 1'b0;
    rand_all(1'b0);
    set4(4'b1110, 4'b1001, 1'b1);
    tick("hold");
    check("hold_sum4", o_res[0], 32'h08);
    check("hold_vld4", 32'(o_vld[0]), 32'd0);
    rand_all(1'b0);
    tick("hold2");
    check("hold2_sum4", o_res[0], 32'h08);

    vin = 1'b1;
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      rand_all(1'b1);
      set4(idx[3:0], idx[7:4], idx[8]);
      tick("exh");
    end

    for (int i = 0; i < 300; i++) begin
      vin = ($urandom_range(0, 4) != 0);
      rand_all(1'b1);
      tick("sweep");
    end

    vin = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      a_in[k] = mask_of(k)[15:0]; b_in[k] = mask_of(k)[15:0]; cin_in[k] = 1'b1;
    end
    tick("ones");
    check("w1_ones_const", o_res[1], 32'h3);

    rand_all(1'b0);
    rst_n = 1'b0;
    tick("midrst");
    rst_n = 1'b1;
    rand_all(1'b0);
    tick("after_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
